// File: rtl/count_iter_pkg.sv
// Shared types and default constants for the iteration counter/sequencer.
package count_iter_pkg;

  localparam int unsigned W_DEF         = 5;
  localparam int unsigned DEF_ITERS_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/count_iter_ctrl.sv
// Iteration counter for iterative datapaths: load a count, decrement per SH, flag completion.
// Optional macro COUNT_ITER_AUTORELOAD_EN: SH in DONE reloads the last loaded count.
module count_iter_ctrl
  import count_iter_pkg::*;
#(
  parameter int unsigned W         = W_DEF,
  parameter int unsigned DEF_ITERS = DEF_ITERS_DEF
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         LD,
  input  logic         LOAD_SEL,
  input  logic [W-1:0] N_IN,
  input  logic         SH,
  output logic [W-1:0] COUNT,
  output logic         BUSY,
  output logic         Z,
  output logic         Z_PULSE,
  output logic         ERR
);

  state_t       state, state_nxt;
  logic [W-1:0] count_nxt;
  logic [W-1:0] load_val;
  logic         err_nxt;
  logic         zp_nxt;

`ifdef COUNT_ITER_AUTORELOAD_EN
  logic [W-1:0] shadow;
`endif

  assign load_val = LOAD_SEL ? N_IN : W'(DEF_ITERS);

  // Next state: LD beats SH; SH outside RUN is flagged rather than acted on.
  always_comb begin
    state_nxt = state;
    count_nxt = COUNT;
    err_nxt   = ERR;
    zp_nxt    = 1'b0;
    if (LD) begin
      count_nxt = load_val;
      err_nxt   = 1'b0;
      if (load_val != '0) begin
        state_nxt = RUN;
      end else begin
        state_nxt = DONE;
        zp_nxt    = 1'b1;
      end
    end else if (SH) begin
      case (state)
        RUN: begin
          if (COUNT > W'(1)) begin
            count_nxt = COUNT - W'(1);
          end else begin
            count_nxt = '0;
            state_nxt = DONE;
            zp_nxt    = 1'b1;
          end
        end
        DONE: begin
`ifdef COUNT_ITER_AUTORELOAD_EN
          if (shadow != '0) begin
            count_nxt = shadow;
            state_nxt = RUN;
          end else begin
            zp_nxt = 1'b1;
          end
`else
          err_nxt = 1'b1;
`endif
        end
        default: err_nxt = 1'b1;
      endcase
    end
  end

  // State, count and flags; BUSY/Z are decoded from the next state so they align with COUNT.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      COUNT   <= '0;
      BUSY    <= 1'b0;
      Z       <= 1'b0;
      Z_PULSE <= 1'b0;
      ERR     <= 1'b0;
`ifdef COUNT_ITER_AUTORELOAD_EN
      shadow  <= '0;
`endif
    end else begin
      state   <= state_nxt;
      COUNT   <= count_nxt;
      BUSY    <= (state_nxt == RUN);
      Z       <= (state_nxt == DONE);
      Z_PULSE <= zp_nxt;
      ERR     <= err_nxt;
`ifdef COUNT_ITER_AUTORELOAD_EN
      if (LD) shadow <= load_val;
`endif
    end
  end

endmodule

// File: tb/tb_count_iter_ctrl.sv
// Directed self-checking bench: default (W=5, DEF=8) and wide (W=8, DEF=200) instances.
module tb_count_iter_ctrl;

  logic       CLK;
  logic       RST_N;
  logic       LD, LOAD_SEL, SH;
  logic [4:0] N_IN;
  logic [4:0] COUNT;
  logic       BUSY, Z, Z_PULSE, ERR;

  logic       b_ld, b_sel, b_sh;
  logic [7:0] b_n_in;
  logic [7:0] b_count;
  logic       b_busy, b_z, b_zp, b_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0]  obs, exp_v;
  logic [11:0] b_obs, b_exp;

  count_iter_ctrl #(.W(5), .DEF_ITERS(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .LD(LD), .LOAD_SEL(LOAD_SEL), .N_IN(N_IN), .SH(SH),
    .COUNT(COUNT), .BUSY(BUSY), .Z(Z), .Z_PULSE(Z_PULSE), .ERR(ERR)
  );

  count_iter_ctrl #(.W(8), .DEF_ITERS(200)) dut_wide (
    .CLK(CLK), .RST_N(RST_N), .LD(b_ld), .LOAD_SEL(b_sel), .N_IN(b_n_in), .SH(b_sh),
    .COUNT(b_count), .BUSY(b_busy), .Z(b_z), .Z_PULSE(b_zp), .ERR(b_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic string fmt(input logic [7:0] c, input logic [3:0] f);
    return $sformatf("cnt=%0d busy=%b z=%b zp=%b err=%b", c, f[3], f[2], f[1], f[0]);
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; LD = 0; LOAD_SEL = 0; SH = 0; N_IN = '0;
    b_ld = 0; b_sel = 0; b_sh = 0; b_n_in = '0;
    #12;
    obs = {COUNT, BUSY, Z, Z_PULSE, ERR}; exp_v = 9'b0;
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL reset: got %s want %s", fmt(8'(obs[8:4]), obs[3:0]), fmt(8'(exp_v[8:4]), exp_v[3:0]));
    end
    b_obs = {b_count, b_busy, b_z, b_zp, b_err}; b_exp = 12'b0;
    n_checks++;
    if (b_obs !== b_exp) begin
      n_fail++; $display("FAIL reset_wide: got %s want %s", fmt(b_obs[11:4], b_obs[3:0]), fmt(b_exp[11:4], b_exp[3:0]));
    end
    @(negedge CLK);
    RST_N = 1'b1;
    step();
  endtask

  task automatic test_default_run();
    LD = 1; LOAD_SEL = 0; SH = 0;
    step();
    obs = {COUNT, BUSY, Z, Z_PULSE, ERR}; exp_v = {5'd8, 4'b1000};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL def_load: got %s want %s", fmt(8'(obs[8:4]), obs[3:0]), fmt(8'(exp_v[8:4]), exp_v[3:0]));
    end
    LD = 0; SH = 1;
    for (int i = 1; i <= 8; i++) begin
      step();
      obs = {COUNT, BUSY, Z, Z_PULSE, ERR};
      exp_v = (i < 8) ? {5'(8 - i), 4'b1000} : {5'd0, 4'b0110};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL def_sh%0d: got %s want %s", i, fmt(8'(obs[8:4]), obs[3:0]), fmt(8'(exp_v[8:4]), exp_v[3:0]));
      end
    end
    SH = 0;
    step();
    obs = {COUNT, BUSY, Z, Z_PULSE, ERR}; exp_v = {5'd0, 4'b0100};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL def_hold: got %s want %s", fmt(8'(obs[8:4]), obs[3:0]), fmt(8'(exp_v[8:4]), exp_v[3:0]));
    end
  endtask

  task automatic test_runtime_count();
    logic       sh_pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [4:0] cnt_exp[4] = '{5'd2, 5'd2, 5'd1, 5'd0};
    LD = 1; LOAD_SEL = 1; N_IN = 5'd3; SH = 0;
    step();
    obs = {COUNT, BUSY, Z, Z_PULSE, ERR}; exp_v = {5'd3, 4'b1000};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL rt_load: got %s want %s", fmt(8'(obs[8:4]), obs[3:0]), fmt(8'(exp_v[8:4]), exp_v[3:0]));
    end
    LD = 0;
    for (int i = 0; i < 4; i++) begin
      SH = sh_pat[i];
      step();
      obs = {COUNT, BUSY, Z, Z_PULSE, ERR};
      exp_v = (i < 3) ? {cnt_exp[i], 4'b1000} : {cnt_exp[i], 4'b0110};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL rt_cyc%0d: got %s want %s", i, fmt(8'(obs[8:4]), obs[3:0]), fmt(8'(exp_v[8:4]), exp_v[3:0]));
      end
    end
    SH = 0;
  endtask

  task automatic test_zero_load();
    LD = 1; LOAD_SEL = 1; N_IN = 5'd0; SH = 0;
    step();
    obs = {COUNT, BUSY, Z, Z_PULSE, ERR}; exp_v = {5'd0, 4'b0110};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL zero_load: got %s want %s", fmt(8'(obs[8:4]), obs[3:0]), fmt(8'(exp_v[8:4]), exp_v[3:0]));
    end
    LD = 0;
    step();
    obs = {COUNT, BUSY, Z, Z_PULSE, ERR}; exp_v = {5'd0, 4'b0100};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL zero_pulse_end: got %s want %s", fmt(8'(obs[8:4]), obs[3:0]), fmt(8'(exp_v[8:4]), exp_v[3:0]));
    end
    SH = 1;
    step();
    obs = {COUNT, BUSY, Z, Z_PULSE, ERR};
`ifdef COUNT_ITER_AUTORELOAD_EN
    exp_v = {5'd0, 4'b0110};
`else
    exp_v = {5'd0, 4'b0101};
`endif
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL done_sh: got %s want %s", fmt(8'(obs[8:4]), obs[3:0]), fmt(8'(exp_v[8:4]), exp_v[3:0]));
    end
    SH = 0; LD = 1; LOAD_SEL = 0;
    step();
    obs = {COUNT, BUSY, Z, Z_PULSE, ERR}; exp_v = {5'd8, 4'b1000};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL err_clear: got %s want %s", fmt(8'(obs[8:4]), obs[3:0]), fmt(8'(exp_v[8:4]), exp_v[3:0]));
    end
    LD = 0;
  endtask

  task automatic test_back_to_back();
    LD = 1; LOAD_SEL = 1; N_IN = 5'd0; SH = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      obs = {COUNT, BUSY, Z, Z_PULSE, ERR}; exp_v = {5'd0, 4'b0110};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL b2b_zero%0d: got %s want %s", i, fmt(8'(obs[8:4]), obs[3:0]), fmt(8'(exp_v[8:4]), exp_v[3:0]));
      end
    end
    LD = 0;
    step();
  endtask

  task automatic test_ld_priority();
    LD = 1; LOAD_SEL = 0; SH = 0;
    step();
    LD = 0; SH = 1;
    repeat (7) step();
    obs = {COUNT, BUSY, Z, Z_PULSE, ERR}; exp_v = {5'd1, 4'b1000};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL prio_pre: got %s want %s", fmt(8'(obs[8:4]), obs[3:0]), fmt(8'(exp_v[8:4]), exp_v[3:0]));
    end
    LD = 1;
    step();
    obs = {COUNT, BUSY, Z, Z_PULSE, ERR}; exp_v = {5'd8, 4'b1000};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL prio_ld: got %s want %s", fmt(8'(obs[8:4]), obs[3:0]), fmt(8'(exp_v[8:4]), exp_v[3:0]));
    end
    LD = 0; SH = 0;
  endtask

  task automatic test_async_reset();
    LD = 1; LOAD_SEL = 0; SH = 0;
    step();
    LD = 0; SH = 1;
    repeat (3) step();
    SH = 0;
    obs = {COUNT, BUSY, Z, Z_PULSE, ERR}; exp_v = {5'd5, 4'b1000};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL arst_pre: got %s want %s", fmt(8'(obs[8:4]), obs[3:0]), fmt(8'(exp_v[8:4]), exp_v[3:0]));
    end
    #2 RST_N = 1'b0;
    #1;
    obs = {COUNT, BUSY, Z, Z_PULSE, ERR}; exp_v = 9'b0;
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL arst_now: got %s want %s", fmt(8'(obs[8:4]), obs[3:0]), fmt(8'(exp_v[8:4]), exp_v[3:0]));
    end
    RST_N = 1'b1;
    repeat (3) step();
    obs = {COUNT, BUSY, Z, Z_PULSE, ERR}; exp_v = 9'b0;
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL arst_idle: got %s want %s", fmt(8'(obs[8:4]), obs[3:0]), fmt(8'(exp_v[8:4]), exp_v[3:0]));
    end
    SH = 1;
    step();
    obs = {COUNT, BUSY, Z, Z_PULSE, ERR}; exp_v = {5'd0, 4'b0001};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL idle_sh_err: got %s want %s", fmt(8'(obs[8:4]), obs[3:0]), fmt(8'(exp_v[8:4]), exp_v[3:0]));
    end
    SH = 0;
  endtask

  task automatic test_wide();
    b_ld = 1; b_sel = 0; b_sh = 0;
    step();
    b_obs = {b_count, b_busy, b_z, b_zp, b_err}; b_exp = {8'd200, 4'b1000};
    n_checks++;
    if (b_obs !== b_exp) begin
      n_fail++; $display("FAIL wide_load: got %s want %s", fmt(b_obs[11:4], b_obs[3:0]), fmt(b_exp[11:4], b_exp[3:0]));
    end
    b_ld = 0; b_sh = 1;
    repeat (199) step();
    b_obs = {b_count, b_busy, b_z, b_zp, b_err}; b_exp = {8'd1, 4'b1000};
    n_checks++;
    if (b_obs !== b_exp) begin
      n_fail++; $display("FAIL wide_199: got %s want %s", fmt(b_obs[11:4], b_obs[3:0]), fmt(b_exp[11:4], b_exp[3:0]));
    end
    step();
    b_obs = {b_count, b_busy, b_z, b_zp, b_err}; b_exp = {8'd0, 4'b0110};
    n_checks++;
    if (b_obs !== b_exp) begin
      n_fail++; $display("FAIL wide_done: got %s want %s", fmt(b_obs[11:4], b_obs[3:0]), fmt(b_exp[11:4], b_exp[3:0]));
    end
    step();
    b_obs = {b_count, b_busy, b_z, b_zp, b_err};
`ifdef COUNT_ITER_AUTORELOAD_EN
    b_exp = {8'd200, 4'b1000};
`else
    b_exp = {8'd0, 4'b0101};
`endif
    n_checks++;
    if (b_obs !== b_exp) begin
      n_fail++; $display("FAIL wide_extra_sh: got %s want %s", fmt(b_obs[11:4], b_obs[3:0]), fmt(b_exp[11:4], b_exp[3:0]));
    end
    b_sh = 0;
  endtask

  initial begin
    test_reset();
    test_default_run();
    test_runtime_count();
    test_zero_load();
    test_back_to_back();
    test_ld_priority();
    test_async_reset();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
